uart_tx_byte_queue: RTL and testbench
=====================================

# uart_tx_byte_queue

Byte queue and launch sequencer placed directly upstream of the UART transmitter. It buffers bytes written by the host side, then hands them to the transmitter one at a time by driving the transmitter's `i_Tx_DV` and data inputs. It waits for the transmitter's done pulse before launching the next byte. An optional watchdog recovers the queue if a done pulse never arrives.

## Interface
- `DEPTH`, 16: queue entries; power of two, minimum 2.
- `CLKS_PER_BIT`, 5208: bit period in clocks; must match the transmitter.
- `TIMEOUT_CLKS`, 11*CLKS_PER_BIT: watchdog limit in clocks, counted in WAIT.

- `i_Clock`  in  1  single clock domain, rising edge.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Enable`  in  1  launch permit; writes are accepted regardless of this input.
- `i_Wr_DV`  in  1  write strobe, one byte per cycle.
- `i_Wr_Byte`  in  8  byte to enqueue.
- `i_Tx_Active`  in  1  transmitter busy, from the transmitter.
- `i_Tx_Done`  in  1  one-cycle done pulse from the transmitter.
- `o_Tx_DV`  out  1  one-cycle launch pulse; connects to the transmitter's `i_Tx_DV`.
- `o_Tx_Byte`  out  8  byte being launched; held stable until the next launch.
- `o_Full`  out  1  count == DEPTH.
- `o_Empty`  out  1  count == 0.
- `o_Count`  out  $clog2(DEPTH)+1  entries currently stored.
- `o_Overflow`  out  1  sticky: a write was dropped.
- `o_Timeout`  out  1  sticky: the watchdog fired.

## Operation
- Storage is a circular buffer `mem[DEPTH]` with read/write pointers of width $clog2(DEPTH). Pointers wrap modulo DEPTH naturally.
- A write is accepted when `i_Wr_DV` is high and `o_Full` is low. On acceptance: mem[wr] <= i_Wr_Byte, wr++.
- A write while full is dropped and sets `o_Overflow`. It is dropped even if a pop occurs in the same cycle, because full is judged on registered count.
- FSM states: IDLE, LAUNCH, WAIT (2-bit encoding).
  - IDLE -> LAUNCH when count>0, `i_Enable` is high and `i_Tx_Active` is low. On this edge: o_Tx_Byte <= mem[rd], rd++.
  - LAUNCH -> WAIT unconditionally after one cycle.
  - WAIT -> IDLE on `i_Tx_Done`.
- `o_Tx_DV` = (state == LAUNCH). It is decoded from the state register, so it is glitch-free and lasts exactly one cycle.
- Count update: +1 on accepted write, -1 on pop, unchanged when both or neither occur.
- No bypass path: a byte written in the same cycle the queue is empty is not launched in that cycle.
- `i_Enable` low holds the FSM in IDLE. An in-flight byte (LAUNCH/WAIT) completes normally.
- `o_Overflow` and `o_Timeout` clear only on reset.

## Timing
- Reset values: state IDLE, pointers 0, count 0, o_Tx_DV 0, o_Tx_Byte 8'h00, o_Empty 1, o_Full 0, o_Overflow 0, o_Timeout 0.
- Latency, empty idle queue: write at cycle N; count=1 at N+1; o_Tx_Byte valid and o_Tx_DV high at N+2.
- Back-to-back launch: done pulse at cycle M gives IDLE at M+1. The next o_Tx_DV occurs no earlier than M+2, and only once `i_Tx_Active` is low.
- Reset mid-transfer: the queue clears immediately. An external transmitter still active blocks the next launch through `i_Tx_Active`.
- A `i_Tx_Done` pulse outside WAIT is ignored.
- Write and pop in the same cycle at count=DEPTH: pop occurs, write is dropped, and o_Overflow=1. The next cycle shows count=DEPTH-1.

## Configuration
- `UART_TXQ_WATCHDOG_EN` defined:
  - A cycle counter runs in WAIT and is cleared on entering WAIT.
  - If it reaches TIMEOUT_CLKS-1 without `i_Tx_Done`, the FSM goes to IDLE and sets `o_Timeout`.
  - Done and timeout in the same cycle count as done: o_Timeout is not set.
- Not defined: no counter is built, WAIT is left only on `i_Tx_Done`, and `o_Timeout` is tied to 0.

## Test plan
- Reset, then write 8'hA5 with i_Enable=1 and i_Tx_Active=0 -> o_Tx_DV high for exactly one cycle, 2 cycles after the write; o_Tx_Byte=8'hA5; count returns to 0.
- Write 3 bytes 8'h11, 8'h22, 8'h33 back-to-back, with the model transmitter returning done 10 cycles after each launch -> three launches in order, each launch at least 2 cycles after the prior done.
- DEPTH=16, i_Enable=0, write 17 bytes -> o_Full=1 after 16; the 17th is dropped; o_Overflow=1; count=16. Then raise i_Enable -> the 16 bytes launch in write order.
- Launch with no done returned, TIMEOUT_CLKS=50, macro defined -> o_Timeout=1 and state IDLE 50 cycles after entering WAIT; the next queued byte launches.
- Assert i_Reset in WAIT with 4 bytes queued -> next cycle count=0, o_Empty=1, o_Tx_DV=0, sticky flags 0; no launch while i_Tx_Active stays high.

Source files
------------

// File: rtl/uart_tx_byte_queue.sv
// Byte queue and launch sequencer feeding a UART transmitter.
// Optional WAIT-state watchdog is built when UART_TXQ_WATCHDOG_EN is defined.
module uart_tx_byte_queue #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned TIMEOUT_CLKS = 11 * CLKS_PER_BIT
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Enable,
  input  logic                       i_Wr_DV,
  input  logic [7:0]                 i_Wr_Byte,
  input  logic                       i_Tx_Active,
  input  logic                       i_Tx_Done,
  output logic                       o_Tx_DV,
  output logic [7:0]                 o_Tx_Byte,
  output logic                       o_Full,
  output logic                       o_Empty,
  output logic [$clog2(DEPTH):0]     o_Count,
  output logic                       o_Overflow,
  output logic                       o_Timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CLKS < 2) begin : g_bad_param
    $error("uart_tx_byte_queue: DEPTH must be a power of two >= 2 and TIMEOUT_CLKS >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            overflow_q, overflow_d;
  logic            full, empty, wr_acc, pop, wd_fire;

  // Full/empty come from the registered count, so a same-cycle pop never frees a slot.
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = i_Wr_DV && !full;
  assign pop    = (state_q == S_IDLE) && !empty && i_Enable && !i_Tx_Active;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_byte_d  = tx_byte_q;
    overflow_d = overflow_q | (i_Wr_DV && full);

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      tx_byte_d = mem_q[rd_ptr_q];
    end

    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE:   if (pop) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (i_Tx_Done || wd_fire) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_byte_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge i_Clock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end

`ifdef UART_TXQ_WATCHDOG_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS);

  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_q, timeout_d;

  assign wd_fire = (state_q == S_WAIT) && (wd_cnt_q == TW'(TIMEOUT_CLKS - 1));

  // Counter is zero outside WAIT; a done pulse on the firing cycle wins over the timeout.
  always_comb begin
    wd_cnt_d  = '0;
    timeout_d = timeout_q;
    if (state_q == S_WAIT && !i_Tx_Done) begin
      if (wd_fire) timeout_d = 1'b1;
      else         wd_cnt_d  = wd_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_Timeout = timeout_q;
`else
  assign wd_fire   = 1'b0;
  assign o_Timeout = 1'b0;
`endif

  assign o_Tx_DV    = (state_q == S_LAUNCH);
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Full     = full;
  assign o_Empty    = empty;
  assign o_Count    = count_q;
  assign o_Overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_byte_queue.sv
// Scoreboard bench for uart_tx_byte_queue with a simple transmitter model.
// The timeout scenario depends on whether UART_TXQ_WATCHDOG_EN is defined.
module tb_uart_tx_byte_queue;

  localparam int unsigned DEPTH = 16;

  logic       i_Clock = 1'b0;
  logic       i_Reset, i_Enable, i_Wr_DV, i_Tx_Active, i_Tx_Done;
  logic [7:0] i_Wr_Byte;
  logic       o_Tx_DV, o_Full, o_Empty, o_Overflow, o_Timeout;
  logic [7:0] o_Tx_Byte;
  logic [4:0] o_Count;

  uart_tx_byte_queue #(.DEPTH(DEPTH), .CLKS_PER_BIT(5), .TIMEOUT_CLKS(50)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Enable(i_Enable),
    .i_Wr_DV(i_Wr_DV), .i_Wr_Byte(i_Wr_Byte),
    .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done),
    .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte), .o_Full(o_Full), .o_Empty(o_Empty),
    .o_Count(o_Count), .o_Overflow(o_Overflow), .o_Timeout(o_Timeout)
  );

  always #5 i_Clock = ~i_Clock;

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] exp;
  } chk_t;

  chk_t       chk_q[$];
  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int launch_cnt = 0;
  int last_done_cyc = 0;
  bit done_seen = 0;
  bit tx_busy = 0;
  bit tx_hang, tx_hold;

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic push_chk(input string n, input logic [31:0] g, input logic [31:0] e);
    chk_t c;
    c.name = n; c.got = g; c.exp = e;
    chk_q.push_back(c);
  endtask

  task automatic write(input logic [7:0] b, input bit accept);
    i_Wr_DV   = 1'b1;
    i_Wr_Byte = b;
    if (accept) exp_q.push_back(b);
    step();
    i_Wr_DV = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while (!(!tx_busy && o_Empty && exp_q.size() == 0 && !o_Tx_DV) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) push_chk("wait_quiet_expired", 32'd0, 32'd1);
    repeat (3) step();
  endtask

  // Transmitter model: busy after each launch, done pulse 10 cycles later.
  initial begin
    i_Tx_Active = 1'b0;
    i_Tx_Done   = 1'b0;
    forever begin
      @(negedge i_Clock);
      if (o_Tx_DV && !i_Reset && !tx_hang) begin
        tx_busy = 1;
        i_Tx_Active = 1'b1;
        while (tx_hold) @(negedge i_Clock);
        repeat (10) @(negedge i_Clock);
        i_Tx_Done   = 1'b1;
        i_Tx_Active = 1'b0;
        last_done_cyc = cyc;
        done_seen = 1;
        @(negedge i_Clock);
        i_Tx_Done = 1'b0;
        tx_busy = 0;
      end
    end
  end

  // Monitor: sole owner of the counters; compares launches and queued direct checks.
  task automatic compare(input string n, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", n, g, e, cyc);
    end
  endtask

  initial begin
    chk_t c;
    bit   prev_dv = 0;
    forever begin
      @(negedge i_Clock);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        compare(c.name, c.got, c.exp);
      end
      if (!i_Reset) begin
        if (prev_dv) compare("dv_one_cycle", 32'(o_Tx_DV), 32'd0);
        if (o_Tx_DV) begin
          launch_cnt++;
          if (exp_q.size() == 0) compare("unexpected_launch", 32'(o_Tx_Byte), 32'hFFFF_FFFF);
          else compare("tx_byte", 32'(o_Tx_Byte), 32'(exp_q.pop_front()));
          if (done_seen) compare("launch_gap_ok", 32'(cyc - last_done_cyc >= 2), 32'd1);
        end
      end
      prev_dv = o_Tx_DV;
    end
  end

  initial begin
    int lc0;
    i_Reset = 1'b1; i_Enable = 1'b0; i_Wr_DV = 1'b0; i_Wr_Byte = 8'h00;
    tx_hang = 0; tx_hold = 0;
    repeat (3) step();
    push_chk("rst_count",    32'(o_Count),    32'd0);
    push_chk("rst_empty",    32'(o_Empty),    32'd1);
    push_chk("rst_full",     32'(o_Full),     32'd0);
    push_chk("rst_dv",       32'(o_Tx_DV),    32'd0);
    push_chk("rst_byte",     32'(o_Tx_Byte),  32'h00);
    push_chk("rst_overflow", 32'(o_Overflow), 32'd0);
    push_chk("rst_timeout",  32'(o_Timeout),  32'd0);
    i_Reset = 1'b0;
    step();

    // Single byte: count=1 at N+1, launch at N+2.
    i_Enable = 1'b1;
    write(8'hA5, 1);
    push_chk("t1_count_n1", 32'(o_Count), 32'd1);
    push_chk("t1_dv_n1",    32'(o_Tx_DV), 32'd0);
    step();
    push_chk("t1_dv_n2",    32'(o_Tx_DV),   32'd1);
    push_chk("t1_byte_n2",  32'(o_Tx_Byte), 32'hA5);
    push_chk("t1_count_n2", 32'(o_Count),   32'd0);
    step();
    push_chk("t1_byte_hold", 32'(o_Tx_Byte), 32'hA5);
    wait_quiet(100);

    // Three back-to-back bytes, launched in order after each done.
    lc0 = launch_cnt;
    write(8'h11, 1); write(8'h22, 1); write(8'h33, 1);
    wait_quiet(200);
    push_chk("t2_launches", 32'(launch_cnt - lc0), 32'd3);

    // Fill while disabled, overflow, then write+pop at full.
    i_Enable = 1'b0;
    for (int i = 0; i < 16; i++) write(8'h40 + 8'(i), 1);
    push_chk("t3_full",      32'(o_Full),     32'd1);
    push_chk("t3_count16",   32'(o_Count),    32'd16);
    push_chk("t3_no_ovf",    32'(o_Overflow), 32'd0);
    write(8'hEE, 0);
    push_chk("t3_ovf",       32'(o_Overflow), 32'd1);
    push_chk("t3_count_drop", 32'(o_Count),   32'd16);
    lc0 = launch_cnt;
    i_Enable = 1'b1;
    write(8'h77, 0);
    push_chk("t3_count15",   32'(o_Count),    32'd15);
    push_chk("t3_dv_launch", 32'(o_Tx_DV),    32'd1);
    wait_quiet(600);
    push_chk("t3_launches",  32'(launch_cnt - lc0), 32'd16);
    push_chk("t3_ovf_sticky", 32'(o_Overflow), 32'd1);

`ifdef UART_TXQ_WATCHDOG_EN
    // Lost done pulse: watchdog returns to IDLE 50 cycles into WAIT.
    i_Enable = 1'b0;
    tx_hang = 1;
    write(8'h5A, 1); write(8'hC3, 1);
    i_Enable = 1'b1;
    step();
    push_chk("t4_dv_first", 32'(o_Tx_DV), 32'd1);
    step();
    tx_hang = 0;
    repeat (49) step();
    push_chk("t4_to_before", 32'(o_Timeout), 32'd0);
    step();
    push_chk("t4_to_set",    32'(o_Timeout), 32'd1);
    push_chk("t4_dv_idle",   32'(o_Tx_DV),   32'd0);
    step();
    push_chk("t4_dv_next",   32'(o_Tx_DV),   32'd1);
    wait_quiet(100);
    push_chk("t4_to_sticky", 32'(o_Timeout), 32'd1);
`else
    // Without the watchdog, WAIT is left only on done.
    i_Enable = 1'b0;
    tx_hold = 1;
    write(8'h5A, 1); write(8'hC3, 1);
    lc0 = launch_cnt;
    i_Enable = 1'b1;
    repeat (60) step();
    push_chk("t4_stuck_launches", 32'(launch_cnt - lc0), 32'd1);
    push_chk("t4_no_timeout",     32'(o_Timeout),        32'd0);
    push_chk("t4_count1",         32'(o_Count),          32'd1);
    tx_hold = 0;
    wait_quiet(100);
    push_chk("t4_launches", 32'(launch_cnt - lc0), 32'd2);
`endif

    // Reset in WAIT with 4 queued while transmitter stays active.
    i_Enable = 1'b0;
    tx_hold = 1;
    for (int i = 0; i < 5; i++) write(8'h61 + 8'(i), 1);
    i_Enable = 1'b1;
    step();
    push_chk("t5_dv", 32'(o_Tx_DV), 32'd1);
    step();
    push_chk("t5_count4", 32'(o_Count), 32'd4);
    i_Reset = 1'b1;
    step();
    i_Reset = 1'b0;
    exp_q.delete();
    push_chk("t5_count0",   32'(o_Count),    32'd0);
    push_chk("t5_empty",    32'(o_Empty),    32'd1);
    push_chk("t5_dv0",      32'(o_Tx_DV),    32'd0);
    push_chk("t5_byte0",    32'(o_Tx_Byte),  32'h00);
    push_chk("t5_ovf0",     32'(o_Overflow), 32'd0);
    push_chk("t5_to0",      32'(o_Timeout),  32'd0);
    lc0 = launch_cnt;
    repeat (20) step();
    push_chk("t5_no_launch_active", 32'(launch_cnt - lc0), 32'd0);
    tx_hold = 0;
    repeat (20) step();
    push_chk("t5_no_launch_after", 32'(launch_cnt - lc0), 32'd0);
    push_chk("t5_still_empty",     32'(o_Empty),          32'd1);

    wait_quiet(100);
    push_chk("sb_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
